// File: rtl/spu_result_queue.sv
// Result-record FIFO between the SPU result encoder and the NOU response arbiter.
// Absorbs non-stallable bursts, drops and flags on overflow, keeps saturating stats.
module spu_result_queue #(
  parameter int unsigned SID_W    = 4,
  parameter int unsigned PKT_ID_W = 16,
  parameter int unsigned TYPE_W   = 4,
  parameter int unsigned ERR_W    = 5,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [SID_W-1:0]    in_sid,
  input  logic [TYPE_W-1:0]   in_type,
  input  logic [PKT_ID_W-1:0] in_pkt_id,
  input  logic                in_status,
  input  logic [ERR_W-1:0]    in_err_code,
  output logic                rsp_vld,
  input  logic                rsp_ready,
  output logic [SID_W-1:0]    rsp_sid,
  output logic [TYPE_W-1:0]   rsp_type,
  output logic [PKT_ID_W-1:0] rsp_pkt_id,
  output logic                rsp_status,
  output logic [ERR_W-1:0]    rsp_err_code,
  output logic [AW:0]         fill_level,
  output logic                almost_full,
  output logic                ovf_sticky,
  input  logic                ovf_clr,
  output logic [CNT_W-1:0]    ok_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic [SID_W-1:0]    last_err_sid,
  output logic [ERR_W-1:0]    last_err_code
);

  localparam int unsigned REC_W = SID_W + TYPE_W + PKT_ID_W + 1 + ERR_W;
  localparam logic [AW:0] AF_LVL = (AW+1)'(DEPTH - 1);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_ovf;
  logic [CNT_W-1:0] r_ok_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [SID_W-1:0] r_last_sid;
  logic [ERR_W-1:0] r_last_code;

  logic [AW:0] w_fill;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  always_comb begin
    w_fill  = r_wr_ptr - r_rd_ptr;
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
    w_pop   = !w_empty && rsp_ready;
    // a pop in the same cycle frees the slot, so a full queue still accepts
    w_push  = in_vld && (!w_full || w_pop);
    w_drop  = in_vld && w_full && !w_pop;
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= {in_sid, in_type, in_pkt_id, in_status, in_err_code};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ovf       <= 1'b0;
      r_ok_cnt    <= '0;
      r_err_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_last_sid  <= '0;
      r_last_code <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != '1)
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (in_vld && !in_status && r_ok_cnt != '1)
        r_ok_cnt <= r_ok_cnt + CNT_W'(1);
      if (in_vld && in_status) begin
        if (r_err_cnt != '1)
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        r_last_sid  <= in_sid;
        r_last_code <= in_err_code;
      end
    end
  end

  assign {rsp_sid, rsp_type, rsp_pkt_id, rsp_status, rsp_err_code} = r_mem[r_rd_ptr[AW-1:0]];
  assign rsp_vld       = !w_empty;
  assign fill_level    = w_fill;
  assign almost_full   = (w_fill >= AF_LVL);
  assign ovf_sticky    = r_ovf;
  assign ok_cnt        = r_ok_cnt;
  assign err_cnt       = r_err_cnt;
  assign drop_cnt      = r_drop_cnt;
  assign last_err_sid  = r_last_sid;
  assign last_err_code = r_last_code;

endmodule

// File: doc/spu_result_queue.md
# spu_result_queue

Buffers the per-packet result records produced by the SPU result encoder and presents them on a valid/ready interface to the NOU response arbiter. The encoder's output is valid-only and cannot be stalled, so this block absorbs bursts, drops records on overflow, and flags every drop. It also maintains saturating OK/error/drop statistics and a last-error capture for the debug CSR block.

## Interface
Parameters:
- SID_W, 4, stream-ID width (matches NOU SID width)
- PKT_ID_W, 16, packet-ID width
- TYPE_W, 4, response-type width
- ERR_W, 5, error-code width
- DEPTH, 8, queue entries; power of two, >= 2
- CNT_W, 16, statistics counter width
- Derived: AW = log2(DEPTH)

Ports (reset is synchronous, active-high):
- clk  in  1  single block clock
- rst  in  1  synchronous reset
- in_vld  in  1  result record present this cycle (from result encoder)
- in_sid  in  SID_W  stream ID
- in_type  in  TYPE_W  response type
- in_pkt_id  in  PKT_ID_W  packet ID
- in_status  in  1  0 = OK, 1 = error
- in_err_code  in  ERR_W  error code; 0 when in_status = 0
- rsp_vld  out  1  head record valid
- rsp_ready  in  1  arbiter accepts head record
- rsp_sid, rsp_type, rsp_pkt_id, rsp_status, rsp_err_code  out  (as inputs)  head record fields
- fill_level  out  AW+1  occupied entries, 0..DEPTH
- almost_full  out  1  fill_level >= DEPTH-1
- ovf_sticky  out  1  at least one record dropped since last clear
- ovf_clr  in  1  single-cycle clear of ovf_sticky
- ok_cnt, err_cnt, drop_cnt  out  CNT_W  saturating statistics
- last_err_sid  out  SID_W  SID of the most recent error record
- last_err_code  out  ERR_W  error code of the most recent error record

## Operation
- Circular buffer: DEPTH entries, each holding {sid, type, pkt_id, status, err_code}. Pointers are AW+1 bits; full when the pointers differ only in the MSB.
- pop = rsp_vld & rsp_ready. push = in_vld & (!full | pop). A record arriving while full is accepted if a pop occurs in the same cycle.
- drop = in_vld & full & !pop. A drop increments drop_cnt and sets ovf_sticky. If ovf_clr and a drop occur in the same cycle, set wins.
- Simultaneous push and pop: fill_level is unchanged, and both pointers advance.
- Output is first-word-fall-through: rsp_* reflect the entry at the read pointer. rsp_vld = (fill_level != 0).
- Once rsp_vld is asserted, it and all rsp_* fields stay stable until pop. The field values are don't-care while rsp_vld = 0.
- Every in_vld record is counted, whether accepted or dropped:
  - ok_cnt increments on in_vld & !in_status.
  - err_cnt increments on in_vld & in_status.
- All counters saturate at all-ones and never wrap. The counters are cleared only by rst.
- On in_vld & in_status (accepted or dropped), last_err_sid and last_err_code load in_sid and in_err_code.
- Ordering: records leave in arrival order. No reordering by SID.

## Timing
- Reset (rst high at a clk edge):
  - Pointers, fill_level, rsp_vld, almost_full, ovf_sticky, all counters, last_err_sid and last_err_code go to 0.
  - Storage contents are not reset.
  - in_vld is ignored during any cycle with rst high.
- Reset mid-operation: all queued records are discarded. rsp_vld is 0 in the cycle after the reset edge.
- Write latency: a record pushed at edge N into an empty queue gives rsp_vld = 1, with its fields, after edge N. There is no same-cycle bypass, so minimum input-to-output latency is 1 cycle.
- Pop takes effect at the edge where rsp_vld & rsp_ready is high. The next record is presented immediately after that edge.
- Statistics, ovf_sticky, fill_level and almost_full update at the same edge as the causing push, pop or drop.
- Throughput: one push and one pop per cycle sustained.
- All outputs are registered or decoded from registered state. There is no combinational path from in_* to rsp_*. The only combinational path from rsp_ready is into internal push/drop logic.

## Test plan
- Single record, in_vld 1 cycle {sid=3, pkt_id=0x1234, status=0, err=0}, rsp_ready=1: rsp_vld is high for exactly 1 cycle, one cycle after input, with those fields; ok_cnt=1; fill_level returns to 0.
- Fill with rsp_ready=0: DEPTH=8, 10 back-to-back records. fill_level=8, almost_full high from 7 entries, drop_cnt=2, ovf_sticky=1. Draining then returns records 0..7 in order, and records 8..9 never appear.
- Full queue, then in_vld and rsp_ready high in the same cycle: the record is accepted, drop_cnt is unchanged, fill_level stays 8, and the new record exits last.
- Error capture: records with err codes 0x03 (sid 1), then 0x0A (sid 2), the second arriving while full. Result: err_cnt=2, last_err_sid=2, last_err_code=0x0A, drop_cnt=1.
- ovf_clr asserted in the same cycle as a drop: ovf_sticky remains 1. ovf_clr the next cycle with no drop: ovf_sticky becomes 0.
- Reset mid-burst with 5 entries queued: after the reset edge, rsp_vld=0, fill_level=0 and all counters are 0. The first new record after reset is output correctly.
- Saturation, with CNT_W forced to 4: 20 OK records give ok_cnt=15 and it stays 15.
